// File: rtl/mem_access_pkg.sv
// Shared types and default widths for the memory access controller.
// The VERIFY state exists only when MEM_ACCESS_STORE_VERIFY_EN is defined.
package mem_access_pkg;

  localparam int unsigned MEM_ADDR_W = 2;
  localparam int unsigned MEM_DATA_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
`ifdef MEM_ACCESS_STORE_VERIFY_EN
    ST_VERIFY = 3'd2,
`endif
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller in front of a registered-read data memory.
// Optional store read-back check enabled by MEM_ACCESS_STORE_VERIFY_EN.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_store;

  // Controller FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_store     <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_mem_addr  <= req_addr;
            r_mem_wdata <= req_wdata;
            r_mem_we    <= req_we;
            r_store     <= req_we;
            r_req_ready <= 1'b0;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef MEM_ACCESS_STORE_VERIFY_EN
          r_state <= r_store ? ST_VERIFY : ST_WAIT;
`else
          r_state <= ST_WAIT;
`endif
        end
`ifdef MEM_ACCESS_STORE_VERIFY_EN
        // Address is held so the read-back sees the freshly written word.
        ST_VERIFY: begin
          r_state <= ST_WAIT;
        end
`endif
        ST_WAIT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_store ? '0 : mem_rdata;
`ifdef MEM_ACCESS_STORE_VERIFY_EN
          r_rsp_err   <= r_store && (mem_rdata != r_mem_wdata);
`else
          r_rsp_err   <= 1'b0;
`endif
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a registered read-before-write 4x4 memory.
// Expected values come from vector tables and an array model of memory contents.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 4;
`ifdef MEM_ACCESS_STORE_VERIFY_EN
  localparam int ST_LAT = 4;
`else
  localparam int ST_LAT = 3;
`endif
  localparam int LD_LAT = 3;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem_arr [4];
  logic [DW-1:0] mem_rdata_q;
  logic          load_mem;
  logic          force_zero;
  logic [DW-1:0] ref_mem [4];
  int            n_checks;
  int            n_err;
  int            we_cnt;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read, read-before-write data memory.
  always @(posedge clk) begin
    if (load_mem) begin
      mem_arr[0] <= 4'hA;
      mem_arr[1] <= 4'h3;
      mem_arr[2] <= 4'h9;
      mem_arr[3] <= 4'h6;
    end else begin
      mem_rdata_q <= mem_arr[mem_addr];
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = force_zero ? 4'h0 : mem_rdata_q;

  always @(negedge clk) if (mem_we) we_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access from request to response handshake, checked at every step.
  task automatic run_access(input bit we, input logic [1:0] addr, input logic [3:0] wdata,
                            input logic [3:0] exp_rdata, input bit exp_err, input int exp_lat,
                            input int hold, input string name);
    int edges;
    int wait_cyc;
    int we0;
    int we1;
    @(negedge clk);
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk({name, "_ready"}, 32'(req_ready), 32'd1);
    we0 = we_cnt;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    if (we) ref_mem[addr] = wdata;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({name, "_lat"}, 32'(edges), 32'(exp_lat));
    chk({name, "_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
    chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({name, "_busy"}, 32'(req_ready), 32'd0);
    we1 = we_cnt;
    chk({name, "_we_pulses"}, 32'(we1 - we0), we ? 32'd1 : 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err || req_ready !== 1'b0)
        chk({name, "_hold"}, {rsp_valid, rsp_err, req_ready, 25'd0, rsp_rdata},
            {1'b1, exp_err, 1'b0, 25'd0, exp_rdata});
    end
    if (hold > 0) chk({name, "_hold_no_write"}, 32'(we_cnt - we1), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, "_done"}, {30'd0, rsp_valid, req_ready}, 32'b01);
  endtask

  typedef struct {
    bit         we;
    logic [1:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_rdata;
    int         exp_lat;
    int         hold;
  } vec_t;

  vec_t vecs [8];

  typedef struct {
    bit         we;
    logic [1:0] addr;
    logic [3:0] wdata;
  } sreq_t;

  sreq_t stream [8];
  logic [3:0] exp_q [$];

  initial begin
    n_checks   = 0;
    n_err      = 0;
    we_cnt     = 0;
    rst_n      = 1'b0;
    load_mem   = 1'b1;
    force_zero = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    ref_mem[0] = 4'hA;
    ref_mem[1] = 4'h3;
    ref_mem[2] = 4'h9;
    ref_mem[3] = 4'h6;

    vecs[0] = '{0, 2'd0, 4'h0, 4'hA, LD_LAT, 0};
    vecs[1] = '{1, 2'd2, 4'h7, 4'h0, ST_LAT, 0};
    vecs[2] = '{0, 2'd2, 4'h0, 4'h7, LD_LAT, 0};
    vecs[3] = '{0, 2'd1, 4'h0, 4'h3, LD_LAT, 5};
    vecs[4] = '{1, 2'd3, 4'hC, 4'h0, ST_LAT, 5};
    vecs[5] = '{0, 2'd3, 4'h0, 4'hC, LD_LAT, 1};
    vecs[6] = '{1, 2'd1, 4'h5, 4'h0, ST_LAT, 0};
    vecs[7] = '{0, 2'd1, 4'h0, 4'h5, LD_LAT, 2};

    repeat (2) @(negedge clk);
    load_mem = 1'b0;
    chk("reset_outputs", {26'd0, rsp_valid, rsp_err, mem_we, 3'd0}, 32'd0);
    chk("reset_regs", {24'd0, rsp_rdata, mem_wdata}, 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);

    for (int v = 0; v < 8; v++)
      run_access(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata, 1'b0,
                 vecs[v].exp_lat, vecs[v].hold, $sformatf("vec%0d", v));

    // Reset during the WAIT cycle of a load abandons it with no response.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 2'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {29'd0, rsp_valid, rsp_err, mem_we}, 32'd0);
    chk("midrst_regs", {22'd0, mem_addr, rsp_rdata, mem_wdata}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_no_rsp_after", 32'(rsp_valid), 32'd0);
    run_access(1'b0, 2'd0, 4'h0, 4'hA, 1'b0, LD_LAT, 0, "postrst_load0");

`ifdef MEM_ACCESS_STORE_VERIFY_EN
    run_access(1'b1, 2'd3, 4'hC, 4'h0, 1'b0, 4, 0, "verify_ok");
    force_zero = 1'b1;
    run_access(1'b1, 2'd3, 4'hC, 4'h0, 1'b1, 4, 0, "verify_err");
    force_zero = 1'b0;
`endif

    // Randomized accesses against the array model.
    for (int r = 0; r < 40; r++) begin
      bit         rwe;
      logic [1:0] ra;
      logic [3:0] rd;
      rwe = 1'($urandom_range(0, 1));
      ra  = 2'($urandom_range(0, 3));
      rd  = 4'($urandom_range(0, 15));
      run_access(rwe, ra, rd, rwe ? 4'h0 : ref_mem[ra], 1'b0, rwe ? ST_LAT : LD_LAT,
                 $urandom_range(0, 2), $sformatf("rnd%0d", r));
    end

    // Streamed stores then loads with req_valid and rsp_ready held high.
    for (int s = 0; s < 4; s++) begin
      stream[s]     = '{1'b1, 2'(s), 4'($urandom_range(0, 15))};
      stream[s + 4] = '{1'b0, 2'(s), 4'h0};
    end
    begin
      int i_req;
      int n_rsp;
      int outstanding;
      int cyc;
      i_req = 0;
      n_rsp = 0;
      outstanding = 0;
      cyc = 0;
      rsp_ready = 1'b1;
      while (n_rsp < 8 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (i_req < 8) begin
          req_valid = 1'b1;
          req_we    = stream[i_req].we;
          req_addr  = stream[i_req].addr;
          req_wdata = stream[i_req].wdata;
        end else begin
          req_valid = 1'b0;
        end
        if (rsp_valid) begin
          chk("stream_rsp_vs_accept", 32'(req_ready), 32'd0);
          if (exp_q.size() == 0) chk("stream_unexpected_rsp", 32'd1, 32'd0);
          else chk($sformatf("stream_rdata%0d", n_rsp), 32'(rsp_rdata), 32'(exp_q.pop_front()));
          n_rsp++;
          outstanding = 0;
        end else if (req_ready && i_req < 8) begin
          chk("stream_accept_idle", 32'(outstanding), 32'd0);
          if (stream[i_req].we) begin
            ref_mem[stream[i_req].addr] = stream[i_req].wdata;
            exp_q.push_back(4'h0);
          end else begin
            exp_q.push_back(ref_mem[stream[i_req].addr]);
          end
          outstanding = 1;
          i_req++;
        end
      end
      chk("stream_responses", 32'(n_rsp), 32'd8);
      chk("stream_accepts", 32'(i_req), 32'd8);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
